// File: rtl/uart_tx_fifo_if.sv
// Producer-side and uart_tx-side signals of uart_tx_fifo bundled into one interface.
// slave is the FIFO's view; master is the view of whoever drives the producer and UART side.
interface uart_tx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 4
);
   logic                  i_wr;
   logic [DATA_WIDTH-1:0] i_wr_data;
   logic                  i_clr_ovf;
   logic                  i_uart_busy;
   logic                  o_full;
   logic                  o_empty;
   logic [DEPTH_LOG2:0]   o_count;
   logic                  o_overflow;
   logic                  o_write;
   logic [DATA_WIDTH-1:0] o_data;

   modport slave (
      input  i_wr, i_wr_data, i_clr_ovf, i_uart_busy,
      output o_full, o_empty, o_count, o_overflow, o_write, o_data
   );

   modport master (
      output i_wr, i_wr_data, i_clr_ovf, i_uart_busy,
      input  o_full, o_empty, o_count, o_overflow, o_write, o_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_tx through its i_write/o_busy handshake.
// Define UART_TX_FIFO_STATS_EN to add the o_sent_count / o_drop_count statistics outputs.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   uart_tx_fifo_if.slave bus
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [15:0]   o_sent_count,
   output logic [7:0]    o_drop_count
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wrPtr;
   logic [DEPTH_LOG2-1:0] r_rdPtr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_overflow;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_pop;

   // Full/empty come from the registered count, so a pop in the same cycle never rescues a write.
   assign w_full  = (r_count == C_FULL);
   assign w_empty = (r_count == '0);
   assign w_push  = bus.i_wr && !w_full;
   assign w_drop  = bus.i_wr && w_full;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= bus.i_wr_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_data     <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
            r_data  <= r_mem[r_rdPtr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A drop in the same cycle as a clear must leave the flag set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.i_clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // HOLD waits out uart_tx's registered busy rise before busy is trusted again.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && !bus.i_uart_busy) begin
               w_pop       = 1'b1;
               w_nextState = SEND;
            end
         end
         SEND:    w_nextState = HOLD;
         HOLD:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   assign bus.o_write    = (r_state == SEND);
   assign bus.o_data     = r_data;
   assign bus.o_count    = r_count;
   assign bus.o_full     = w_full;
   assign bus.o_empty    = w_empty;
   assign bus.o_overflow = r_overflow;

`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0] r_sentCount;
   logic [7:0]  r_dropCount;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sentCount <= '0;
         r_dropCount <= '0;
      end else begin
         if (r_state == SEND) begin
            r_sentCount <= r_sentCount + 16'd1;
         end
         if (w_drop && (r_dropCount != 8'hFF)) begin
            r_dropCount <= r_dropCount + 8'd1;
         end
      end
   end

   assign o_sent_count = r_sentCount;
   assign o_drop_count = r_dropCount;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with a small uart_tx busy model.
// Define UART_TX_FIFO_STATS_EN to also check the statistics counters.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

   localparam int DW = 8;
   localparam int DL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   numChecks = 0;
   int   numFails  = 0;

   logic forceBusy = 1'b0;
   logic modelEn   = 1'b0;
   int   busyCnt   = 0;

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) fifoIf ();

`ifdef UART_TX_FIFO_STATS_EN
   logic [15:0] sentCount;
   logic [7:0]  dropCount;
`endif

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (fifoIf.slave)
`ifdef UART_TX_FIFO_STATS_EN
      ,
      .o_sent_count (sentCount),
      .o_drop_count (dropCount)
`endif
   );

   // uart_tx stand-in: busy rises one edge after i_write and stays high for 10 cycles.
   always @(posedge clk) begin
      if (fifoIf.o_write) busyCnt <= 10;
      else if (busyCnt > 0) busyCnt <= busyCnt - 1;
   end

   assign fifoIf.i_uart_busy = forceBusy | (modelEn && (busyCnt != 0));

   task automatic pulseReset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      fifoIf.i_wr      = 1'b0;
      fifoIf.i_wr_data = '0;
      fifoIf.i_clr_ovf = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      numChecks++; if (fifoIf.o_write !== 1'b0) begin numFails++; $display("[TB] FAIL reset_write: got %b expected 0", fifoIf.o_write); end
      numChecks++; if (fifoIf.o_data !== 8'h00) begin numFails++; $display("[TB] FAIL reset_data: got %h expected 00", fifoIf.o_data); end
      numChecks++; if (fifoIf.o_count !== 5'd0) begin numFails++; $display("[TB] FAIL reset_count: got %0d expected 0", fifoIf.o_count); end
      numChecks++; if (fifoIf.o_empty !== 1'b1) begin numFails++; $display("[TB] FAIL reset_empty: got %b expected 1", fifoIf.o_empty); end
      numChecks++; if (fifoIf.o_full !== 1'b0) begin numFails++; $display("[TB] FAIL reset_full: got %b expected 0", fifoIf.o_full); end
      numChecks++; if (fifoIf.o_overflow !== 1'b0) begin numFails++; $display("[TB] FAIL reset_overflow: got %b expected 0", fifoIf.o_overflow); end
`ifdef UART_TX_FIFO_STATS_EN
      numChecks++; if (sentCount !== 16'd0) begin numFails++; $display("[TB] FAIL reset_sent_count: got %0d expected 0", sentCount); end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_write();
      int seenAt = -1;
      int pulses = 0;
      logic [7:0] seenData = '0;
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'h41;
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (fifoIf.o_write) begin
            pulses++;
            if (seenAt < 0) begin seenAt = cyc; seenData = fifoIf.o_data; end
         end
      end
      numChecks++; if (seenAt !== 1) begin numFails++; $display("[TB] FAIL single_latency: got cycle %0d expected 1", seenAt); end
      numChecks++; if (pulses !== 1) begin numFails++; $display("[TB] FAIL single_pulses: got %0d expected 1", pulses); end
      numChecks++; if (seenData !== 8'h41) begin numFails++; $display("[TB] FAIL single_data: got %h expected 41", seenData); end
      numChecks++; if (fifoIf.o_empty !== 1'b1) begin numFails++; $display("[TB] FAIL single_empty: got %b expected 1", fifoIf.o_empty); end
   endtask

   task automatic test_burst();
      logic sawWrite = 1'b0;
      pulseReset();
`ifdef UART_TX_FIFO_STATS_EN
      numChecks++; if (sentCount !== 16'd0) begin numFails++; $display("[TB] FAIL burst_sent_count_reset: got %0d expected 0", sentCount); end
`endif
      forceBusy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'(i);
         @(negedge clk);
         if (fifoIf.o_write) sawWrite = 1'b1;
      end
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b0;
      @(negedge clk);
      if (fifoIf.o_write) sawWrite = 1'b1;
      numChecks++; if (fifoIf.o_full !== 1'b1) begin numFails++; $display("[TB] FAIL burst_full: got %b expected 1", fifoIf.o_full); end
      numChecks++; if (fifoIf.o_count !== 5'd16) begin numFails++; $display("[TB] FAIL burst_count: got %0d expected 16", fifoIf.o_count); end
      numChecks++; if (sawWrite !== 1'b0) begin numFails++; $display("[TB] FAIL burst_no_write: got %b expected 0", sawWrite); end
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'hAA;
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b0;
      @(negedge clk);
      numChecks++; if (fifoIf.o_overflow !== 1'b1) begin numFails++; $display("[TB] FAIL burst_overflow: got %b expected 1", fifoIf.o_overflow); end
      numChecks++; if (fifoIf.o_count !== 5'd16) begin numFails++; $display("[TB] FAIL burst_count_after_drop: got %0d expected 16", fifoIf.o_count); end
`ifdef UART_TX_FIFO_STATS_EN
      numChecks++; if (dropCount !== 8'd1) begin numFails++; $display("[TB] FAIL burst_drop_count: got %0d expected 1", dropCount); end
`endif
   endtask

   task automatic test_drain();
      int pulses = 0;
      int busyViol = 0;
      int doubles = 0;
      logic prevWrite = 1'b0;
      @(posedge clk); #1;
      forceBusy = 1'b0;
      modelEn   = 1'b1;
      for (int cyc = 0; cyc < 350; cyc++) begin
         @(negedge clk);
         if (fifoIf.o_write) begin
            if (fifoIf.i_uart_busy) busyViol++;
            if (prevWrite) doubles++;
            if (pulses < 16) begin
               numChecks++;
               if (fifoIf.o_data !== 8'(pulses)) begin numFails++; $display("[TB] FAIL drain_order[%0d]: got %h expected %h", pulses, fifoIf.o_data, 8'(pulses)); end
            end
            pulses++;
         end
         prevWrite = fifoIf.o_write;
      end
      numChecks++; if (pulses !== 16) begin numFails++; $display("[TB] FAIL drain_pulses: got %0d expected 16", pulses); end
      numChecks++; if (busyViol !== 0) begin numFails++; $display("[TB] FAIL drain_write_while_busy: got %0d expected 0", busyViol); end
      numChecks++; if (doubles !== 0) begin numFails++; $display("[TB] FAIL drain_double_pulse: got %0d expected 0", doubles); end
      numChecks++; if (fifoIf.o_empty !== 1'b1) begin numFails++; $display("[TB] FAIL drain_empty: got %b expected 1", fifoIf.o_empty); end
`ifdef UART_TX_FIFO_STATS_EN
      numChecks++; if (sentCount !== 16'd16) begin numFails++; $display("[TB] FAIL drain_sent_count: got %0d expected 16", sentCount); end
`endif
   endtask

   task automatic test_wrap();
      int rx = 0;
      int maxCount = 0;
      @(posedge clk); #1;
      fifoIf.i_clr_ovf = 1'b1;
      @(posedge clk); #1;
      fifoIf.i_clr_ovf = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               int guard = 0;
               repeat (3) @(posedge clk);
               while (fifoIf.o_count >= 5'd12 && guard < 2000) begin
                  @(posedge clk);
                  guard++;
               end
               #1;
               fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'(8'h30 + i);
               @(posedge clk); #1;
               fifoIf.i_wr = 1'b0;
            end
         end
         begin
            for (int cyc = 0; cyc < 1500 && rx < 40; cyc++) begin
               @(negedge clk);
               if (int'(fifoIf.o_count) > maxCount) maxCount = int'(fifoIf.o_count);
               if (fifoIf.o_write) begin
                  numChecks++;
                  if (fifoIf.o_data !== 8'(8'h30 + rx)) begin numFails++; $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", rx, fifoIf.o_data, 8'(8'h30 + rx)); end
                  rx++;
               end
            end
         end
      join
      numChecks++; if (rx !== 40) begin numFails++; $display("[TB] FAIL wrap_received: got %0d expected 40", rx); end
      numChecks++; if (fifoIf.o_overflow !== 1'b0) begin numFails++; $display("[TB] FAIL wrap_overflow: got %b expected 0", fifoIf.o_overflow); end
      numChecks++; if (maxCount > 15) begin numFails++; $display("[TB] FAIL wrap_occupancy: got %0d expected at most 15", maxCount); end
   endtask

   task automatic test_simultaneous();
      modelEn = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      forceBusy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'(8'h60 + i);
         @(posedge clk); #1;
      end
      fifoIf.i_wr = 1'b0;
      @(negedge clk);
      numChecks++; if (fifoIf.o_count !== 5'd5) begin numFails++; $display("[TB] FAIL simul_prefill: got %0d expected 5", fifoIf.o_count); end
      @(posedge clk); #1;
      forceBusy = 1'b0;
      fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'h65;
      @(posedge clk); #1;
      forceBusy = 1'b1;
      fifoIf.i_wr = 1'b0;
      @(negedge clk);
      numChecks++; if (fifoIf.o_count !== 5'd5) begin numFails++; $display("[TB] FAIL simul_count: got %0d expected 5", fifoIf.o_count); end
      numChecks++; if (fifoIf.o_write !== 1'b1) begin numFails++; $display("[TB] FAIL simul_write: got %b expected 1", fifoIf.o_write); end
      numChecks++; if (fifoIf.o_data !== 8'h60) begin numFails++; $display("[TB] FAIL simul_data: got %h expected 60", fifoIf.o_data); end
      @(posedge clk); #1;
      for (int i = 0; i < 11; i++) begin
         fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'(8'h70 + i);
         @(posedge clk); #1;
      end
      fifoIf.i_wr = 1'b0;
      @(negedge clk);
      numChecks++; if (fifoIf.o_full !== 1'b1) begin numFails++; $display("[TB] FAIL simul_full: got %b expected 1", fifoIf.o_full); end
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'hEE;
      @(posedge clk); #1;
      fifoIf.i_clr_ovf = 1'b1;
      @(posedge clk); #1;
      fifoIf.i_wr = 1'b0; fifoIf.i_clr_ovf = 1'b0;
      @(negedge clk);
      numChecks++; if (fifoIf.o_overflow !== 1'b1) begin numFails++; $display("[TB] FAIL simul_set_wins: got %b expected 1", fifoIf.o_overflow); end
      @(posedge clk); #1;
      fifoIf.i_clr_ovf = 1'b1;
      @(posedge clk); #1;
      fifoIf.i_clr_ovf = 1'b0;
      @(negedge clk);
      numChecks++; if (fifoIf.o_overflow !== 1'b0) begin numFails++; $display("[TB] FAIL simul_clear: got %b expected 0", fifoIf.o_overflow); end
      numChecks++; if (fifoIf.o_count !== 5'd16) begin numFails++; $display("[TB] FAIL simul_count_full: got %0d expected 16", fifoIf.o_count); end
   endtask

   task automatic test_reset_mid_send();
      int found = 0;
      pulseReset();
      forceBusy = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         fifoIf.i_wr = 1'b1; fifoIf.i_wr_data = 8'(8'hC0 + i);
         @(posedge clk); #1;
      end
      fifoIf.i_wr = 1'b0;
      forceBusy = 1'b0;
      for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
         @(negedge clk);
         if (fifoIf.o_write) found = 1;
      end
      numChecks++; if (found !== 1) begin numFails++; $display("[TB] FAIL rst_send_reached: got %0d expected 1", found); end
      #1 rst_n = 1'b0;
      #1;
      numChecks++; if (fifoIf.o_write !== 1'b0) begin numFails++; $display("[TB] FAIL rst_write_async: got %b expected 0", fifoIf.o_write); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      numChecks++; if (fifoIf.o_count !== 5'd0) begin numFails++; $display("[TB] FAIL rst_count: got %0d expected 0", fifoIf.o_count); end
      numChecks++; if (fifoIf.o_empty !== 1'b1) begin numFails++; $display("[TB] FAIL rst_empty: got %b expected 1", fifoIf.o_empty); end
      numChecks++; if (fifoIf.o_write !== 1'b0) begin numFails++; $display("[TB] FAIL rst_no_send: got %b expected 0", fifoIf.o_write); end
`ifdef UART_TX_FIFO_STATS_EN
      numChecks++; if (sentCount !== 16'd0) begin numFails++; $display("[TB] FAIL rst_sent_count: got %0d expected 0", sentCount); end
`endif
   endtask

   initial begin
      $display("[TB] Starting uart_tx_fifo tests");
      test_reset();
      test_single_write();
      test_burst();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_reset_mid_send();
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
